// File: rtl/mux_sel_pipe.sv
// Registered NUM_IN-to-1 selector with direct or round-robin channel choice and valid/ready output.
// Latency 1 cycle; word held under backpressure, drain and reload in the same edge for full throughput.
module mux_sel_pipe #(
    parameter int WIDTH  = 16,
    parameter int NUM_IN = 8,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_IN*WIDTH-1:0] in_bus,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_taken,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_chan,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sel_err
);

    localparam int                NSLOT    = 2**SEL_W;
    localparam logic [SEL_W:0]    NUM_IN_L = (SEL_W+1)'(NUM_IN);
    localparam logic [SEL_W-1:0]  LAST_CH  = SEL_W'(NUM_IN-1);

    logic [WIDTH-1:0] r_out_data;
    logic [SEL_W-1:0] r_out_chan;
    logic             r_out_valid;
    logic             r_sel_err;
    logic [SEL_W-1:0] r_ptr;

    logic [WIDTH-1:0] w_ch [NSLOT];
    logic [NSLOT-1:0] w_valid_pad;
    logic [SEL_W:0]   w_sum;
    logic             w_scan_vld;
    logic [SEL_W-1:0] w_scan_idx;
    logic             w_sel_ok;
    logic             w_dir_vld;
    logic             w_win_vld;
    logic [SEL_W-1:0] w_win_idx;
    logic             w_free;
    logic             w_cap;

    // Channels padded to a power of two so any sel value indexes safely.
    always_comb begin
        for (int k = 0; k < NSLOT; k++) begin
            w_ch[k] = '0;
        end
        for (int k = 0; k < NUM_IN; k++) begin
            w_ch[k] = in_bus[k*WIDTH +: WIDTH];
        end
    end

    assign w_valid_pad = NSLOT'(in_valid);

    // Walk offsets from the far end so the nearest requester after r_ptr wins.
    always_comb begin
        w_sum      = '0;
        w_scan_vld = 1'b0;
        w_scan_idx = '0;
        for (int i = NUM_IN-1; i >= 0; i--) begin
            w_sum = {1'b0, r_ptr} + (SEL_W+1)'(i);
            if (w_sum >= NUM_IN_L) begin
                w_sum = w_sum - NUM_IN_L;
            end
            if (w_valid_pad[w_sum[SEL_W-1:0]]) begin
                w_scan_vld = 1'b1;
                w_scan_idx = w_sum[SEL_W-1:0];
            end
        end
    end

    assign w_sel_ok  = ({1'b0, sel} < NUM_IN_L);
    assign w_dir_vld = w_sel_ok & w_valid_pad[sel];
    assign w_win_vld = mode ? w_scan_vld : w_dir_vld;
    assign w_win_idx = mode ? w_scan_idx : sel;
    assign w_free    = !r_out_valid | out_ready;
    assign w_cap     = rst_n & en & w_free & w_win_vld;

    always_comb begin
        in_taken = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            in_taken[k] = w_cap & (w_win_idx == SEL_W'(k));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_chan  <= '0;
            r_out_valid <= 1'b0;
            r_sel_err   <= 1'b0;
            r_ptr       <= '0;
        end else begin
            r_sel_err <= en & !mode & !w_sel_ok;
            if (w_cap) begin
                r_out_data  <= w_ch[w_win_idx];
                r_out_chan  <= w_win_idx;
                r_out_valid <= 1'b1;
                if (mode) begin
                    r_ptr <= (w_win_idx == LAST_CH) ? '0 : w_win_idx + SEL_W'(1);
                end
            end else if (out_ready && r_out_valid) begin
                r_out_data  <= '0;
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_chan  = r_out_chan;
    assign out_valid = r_out_valid;
    assign sel_err   = r_sel_err;

endmodule

// File: tb/tb_mux_sel_pipe.sv
// Bench for mux_sel_pipe: scoreboarded 8-input instance plus a 6-input instance for the bad-select case.
module tb_mux_sel_pipe;

    localparam int W  = 16;
    localparam int N  = 8;
    localparam int SW = 3;
    localparam int N6 = 6;

    typedef struct packed {
        logic [SW-1:0] chan;
        logic [W-1:0]  data;
    } exp_t;

    logic            clk;
    logic            rst_n;
    logic            en;
    logic            mode;
    logic [SW-1:0]   sel;
    logic [N*W-1:0]  in_bus;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_taken;
    logic [W-1:0]    out_data;
    logic [SW-1:0]   out_chan;
    logic            out_valid;
    logic            out_ready;
    logic            sel_err;

    logic [N6-1:0]   in_taken6;
    logic [W-1:0]    out_data6;
    logic [SW-1:0]   out_chan6;
    logic            out_valid6;
    logic            sel_err6;

    exp_t            sb[$];
    int              n_vec;
    int              n_err;
    logic            m_valid;
    logic [SW-1:0]   m_ptr;
    int              seq [5] = '{1, 4, 7, 1, 4};

    mux_sel_pipe #(.WIDTH(W), .NUM_IN(N), .SEL_W(SW)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel),
        .in_bus(in_bus), .in_valid(in_valid), .in_taken(in_taken),
        .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
        .out_ready(out_ready), .sel_err(sel_err)
    );

    mux_sel_pipe #(.WIDTH(W), .NUM_IN(N6), .SEL_W(SW)) dut6 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel),
        .in_bus(in_bus[N6*W-1:0]), .in_valid(in_valid[N6-1:0]), .in_taken(in_taken6),
        .out_data(out_data6), .out_chan(out_chan6), .out_valid(out_valid6),
        .out_ready(out_ready), .sel_err(sel_err6)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic set_ch(input int k, input logic [W-1:0] v);
        in_bus[k*W +: W] = v;
    endtask

    task automatic model_pick(output logic v, output logic [SW-1:0] w);
        v = 1'b0;
        w = '0;
        if (!mode) begin
            v = in_valid[sel];
            w = sel;
        end else begin
            for (int n = 0; n < N; n++) begin
                int k;
                k = (int'(m_ptr) + n) % N;
                if (!v && in_valid[k]) begin
                    v = 1'b1;
                    w = SW'(k);
                end
            end
        end
    endtask

    // Called at posedge+1 with inputs already set; checks before and after the next edge.
    task automatic tick();
        logic          v;
        logic [SW-1:0] w;
        logic          cap;
        logic          err6;
        logic [N-1:0]  exp_tk;
        exp_t          e;
        #3;
        model_pick(v, w);
        cap    = en && (!m_valid || out_ready) && v;
        exp_tk = cap ? (N'(1) << w) : '0;
        chk("in_taken", 32'(in_taken), 32'(exp_tk));
        if (!mode && sel >= SW'(N6)) chk("in_taken6", 32'(in_taken6), 32'(0));
        if (m_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", sb.size(), 1);
            end else begin
                e = sb.pop_front();
                chk("drain_chan", 32'(out_chan), 32'(e.chan));
                chk("drain_data", 32'(out_data), 32'(e.data));
            end
        end
        if (cap) begin
            sb.push_back('{chan: w, data: in_bus[w*W +: W]});
            m_valid = 1'b1;
            if (mode) m_ptr = (w == SW'(N-1)) ? '0 : w + SW'(1);
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        err6 = en && !mode && (sel >= SW'(N6));
        @(posedge clk);
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        if (m_valid) chk("held_data", 32'(out_data), 32'(sb[0].data));
        else         chk("idle_data", 32'(out_data), 32'(0));
        chk("sel_err", 32'(sel_err), 32'(0));
        chk("sel_err6", 32'(sel_err6), 32'(err6));
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        rst_n = 1'b0; en = 1'b0; mode = 1'b0; sel = '0;
        in_bus = '0; in_valid = '0; out_ready = 1'b0;
        m_valid = 1'b0; m_ptr = '0;

        #2;
        chk("rst_valid", 32'(out_valid), 32'(0));
        chk("rst_data",  32'(out_data),  32'(0));
        chk("rst_chan",  32'(out_chan),  32'(0));
        chk("rst_err",   32'(sel_err),   32'(0));
        chk("rst_taken", 32'(in_taken),  32'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;

        // direct select
        for (int k = 0; k < N; k++) set_ch(k, W'(16'h1000 + k));
        set_ch(5, 16'hA5A5);
        en = 1'b1; mode = 1'b0; sel = 3'd5; in_valid = 8'hFF; out_ready = 1'b1;
        tick();
        chk("t2_chan", 32'(out_chan), 32'(5));
        chk("t2_data", 32'(out_data), 32'(16'hA5A5));

        // backpressure hold, then drain and reload on one edge
        out_ready = 1'b0;
        set_ch(5, 16'h1234);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_hold", 32'(out_data), 32'(16'hA5A5));
        end
        out_ready = 1'b1;
        tick();
        chk("t3_load", 32'(out_data), 32'(16'h1234));

        // asynchronous reset between edges while a word is held
        out_ready = 1'b0;
        #1; rst_n = 1'b0; #1;
        chk("t1_valid", 32'(out_valid), 32'(0));
        chk("t1_data",  32'(out_data),  32'(0));
        chk("t1_chan",  32'(out_chan),  32'(0));
        chk("t1_taken", 32'(in_taken),  32'(0));
        @(posedge clk); #1;
        chk("t1_hold_rst", 32'(out_valid), 32'(0));
        rst_n = 1'b1;
        m_valid = 1'b0; m_ptr = '0; sb.delete();
        mode = 1'b1; in_valid = 8'hFF; out_ready = 1'b1;
        tick();
        chk("t1_ptr0", 32'(out_chan), 32'(0));

        // round-robin scan with wrap
        in_valid = 8'b1001_0010;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t4_seq", 32'(out_chan), 32'(seq[i]));
        end

        // enable low drains, then empty scan stays idle
        en = 1'b0;
        tick();
        chk("t5_drain", 32'(out_valid), 32'(0));
        chk("t5_zero",  32'(out_data),  32'(0));
        en = 1'b1; mode = 1'b1; in_valid = '0;
        tick();
        tick();
        chk("t5_empty", 32'(out_valid), 32'(0));

        // out-of-range select on the 6-input instance
        mode = 1'b0; sel = 3'd7; in_valid = 8'hFF; out_ready = 1'b1;
        tick();
        chk("t6_err",   32'(sel_err6),   32'(1));
        chk("t6_nocap", 32'(out_valid6), 32'(0));
        sel = 3'd2;
        tick();
        chk("t6_pulse", 32'(sel_err6),   32'(0));
        chk("t6_cap",   32'(out_valid6), 32'(1));
        chk("t6_chan",  32'(out_chan6),  32'(2));

        // random traffic
        for (int i = 0; i < 400; i++) begin
            en        = ($urandom_range(0, 3) != 0);
            mode      = 1'($urandom_range(0, 1));
            sel       = SW'($urandom_range(0, N-1));
            in_valid  = N'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            set_ch($urandom_range(0, N-1), W'($urandom));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
